ysyx_24120013_regfile_sb: RTL and testbench

General-purpose register file with an integrated scoreboard. It is the consumer end of the execute-stage writeback interface (wen/waddr/wdata) and the producer of the operand fetch values (src1/src2) that feed execute. The scoreboard tracks destination registers of in-flight instructions and raises a stall to decode when an operand is not yet written back.

---
 rtl/ysyx_24120013_regfile_sb_if.sv | 35 +++
 rtl/ysyx_24120013_regfile_sb.sv | 87 ++++++++
 tb/tb_ysyx_24120013_regfile_sb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24120013_regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24120013_regfile_sb_if
// Brief    : Writeback / issue / operand-fetch bundle for the scoreboarded
//            register file (master = pipeline, slave = register file).
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_24120013_regfile_sb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                        wb_wen;
    logic [ADDR_WIDTH-1:0]       wb_waddr;
    logic [DATA_WIDTH-1:0]       wb_wdata;
    logic                        iss_valid;
    logic [ADDR_WIDTH-1:0]       iss_rd;
    logic [ADDR_WIDTH-1:0]       raddr1;
    logic [ADDR_WIDTH-1:0]       raddr2;
    logic [DATA_WIDTH-1:0]       src1;
    logic [DATA_WIDTH-1:0]       src2;
    logic                        stall;
    logic [(2**ADDR_WIDTH)-1:0]  busy_vec;
    logic [31:0]                 wb_count;

    modport master (
        output wb_wen, wb_waddr, wb_wdata, iss_valid, iss_rd, raddr1, raddr2,
        input  src1, src2, stall, busy_vec, wb_count
    );

    modport slave (
        input  wb_wen, wb_waddr, wb_wdata, iss_valid, iss_rd, raddr1, raddr2,
        output src1, src2, stall, busy_vec, wb_count
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_24120013_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24120013_regfile_sb
// Brief    : Register file with per-register busy scoreboard and operand stall.
//            Optional write-to-read forwarding: YSYX_24120013_RF_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24120013_regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    ysyx_24120013_regfile_sb_if.slave   bus
);
    localparam int                 c_NREG = 2**ADDR_WIDTH;
    localparam logic [c_NREG-1:0]  c_ONE  = {{(c_NREG-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_regs [c_NREG];
    logic [c_NREG-1:0]     r_busy;
    logic [31:0]           r_wb_count;

    logic                  w_wb_fire;
    logic                  w_iss_fire;
    logic                  w_fwd1;
    logic                  w_fwd2;
    logic                  w_haz1;
    logic                  w_haz2;
    logic                  w_stall;
    logic [c_NREG-1:0]     w_set_mask;
    logic [c_NREG-1:0]     w_clr_mask;

    assign w_wb_fire  = bus.wb_wen && (bus.wb_waddr != '0);
    assign w_iss_fire = bus.iss_valid && !w_stall && (bus.iss_rd != '0);

`ifdef YSYX_24120013_RF_BYPASS_EN
    assign w_fwd1 = w_wb_fire && (bus.wb_waddr == bus.raddr1);
    assign w_fwd2 = w_wb_fire && (bus.wb_waddr == bus.raddr2);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    // A forwarded operand is already available, so its busy bit must not stall.
    assign w_haz1  = (bus.raddr1 != '0) && r_busy[bus.raddr1] && !w_fwd1;
    assign w_haz2  = (bus.raddr2 != '0) && r_busy[bus.raddr2] && !w_fwd2;
    assign w_stall = bus.iss_valid && (w_haz1 || w_haz2);

    always_comb begin
        bus.src1 = '0;
        bus.src2 = '0;
        if (bus.raddr1 != '0) bus.src1 = w_fwd1 ? bus.wb_wdata : r_regs[bus.raddr1];
        if (bus.raddr2 != '0) bus.src2 = w_fwd2 ? bus.wb_wdata : r_regs[bus.raddr2];
    end

    assign w_set_mask   = w_iss_fire ? (c_ONE << bus.iss_rd)   : '0;
    assign w_clr_mask   = w_wb_fire  ? (c_ONE << bus.wb_waddr) : '0;
    assign bus.stall    = w_stall;
    assign bus.busy_vec = r_busy;
    assign bus.wb_count = r_wb_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_NREG; i++) r_regs[i] <= '0;
        end else if (w_wb_fire) begin
            r_regs[bus.wb_waddr] <= bus.wb_wdata;
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the register busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_count <= '0;
        end else if (w_wb_fire) begin
            r_wb_count <= r_wb_count + 32'd1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ysyx_24120013_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24120013_regfile_sb
// Brief    : Directed bench with an array-based reference model checked on
//            every falling edge, plus literal expectations for key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24120013_regfile_sb;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 2**AW;
`ifdef YSYX_24120013_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_24120013_regfile_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ysyx_24120013_regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arrays and a counter.
    logic [DW-1:0] m_regs [NREG];
    bit            m_busy [NREG];
    logic [31:0]   m_count;

    function automatic logic [DW-1:0] m_src(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYP && bus.wb_wen && bus.wb_waddr != 0 && bus.wb_waddr == a) return bus.wb_wdata;
        return m_regs[a];
    endfunction

    function automatic bit m_blocked(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (BYP && bus.wb_wen && bus.wb_waddr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic m_stall();
        return bus.iss_valid && (m_blocked(bus.raddr1) || m_blocked(bus.raddr2));
    endfunction

    function automatic logic [NREG-1:0] m_busy_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_count = '0;
        end else begin
            automatic logic s = m_stall();
            if (bus.wb_wen && bus.wb_waddr != 0) begin
                m_regs[bus.wb_waddr] = bus.wb_wdata;
                m_busy[bus.wb_waddr] = 1'b0;
                m_count = m_count + 1;
            end
            if (bus.iss_valid && !s && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
        end
    end

    bit model_on = 1'b0;
    always @(negedge clk) begin
        if (model_on) begin
            check("model_src1",  {32'd0, bus.src1},     {32'd0, m_src(bus.raddr1)});
            check("model_src2",  {32'd0, bus.src2},     {32'd0, m_src(bus.raddr2)});
            check("model_stall", {63'd0, bus.stall},    {63'd0, m_stall()});
            check("model_busy",  {32'd0, bus.busy_vec}, {32'd0, m_busy_vec()});
            check("model_count", {32'd0, bus.wb_count}, {32'd0, m_count});
        end
    end

    task automatic idle();
        bus.wb_wen = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.raddr1 = '0; bus.raddr2 = '0;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wb_wen = 1'b1; bus.wb_waddr = a; bus.wb_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        idle();
        #1;
        model_on = 1'b1;
        #2;
        check("reset_src1",  {32'd0, bus.src1},     64'd0);
        check("reset_stall", {63'd0, bus.stall},    64'd0);
        check("reset_busy",  {32'd0, bus.busy_vec}, 64'd0);
        check("reset_count", {32'd0, bus.wb_count}, 64'd0);
        tick(); tick();
        rst = 1'b1;

        // Mid-run asynchronous reset wipes written data immediately.
        wb(5, 32'h1234);
        tick();
        idle(); bus.raddr1 = 5;
        #1 check("reg5_written", {32'd0, bus.src1}, 64'h1234);
        rst = 1'b0;
        #1;
        check("async_rst_reg5",  {32'd0, bus.src1},     64'd0);
        check("async_rst_busy",  {32'd0, bus.busy_vec}, 64'd0);
        check("async_rst_count", {32'd0, bus.wb_count}, 64'd0);
        tick();
        rst = 1'b1;

        // Write / read and x0 discard.
        idle(); wb(3, 32'hDEADBEEF);
        tick();
        idle(); bus.raddr1 = 3;
        #1;
        check("rd_reg3",     {32'd0, bus.src1},     64'hDEADBEEF);
        check("count_one",   {32'd0, bus.wb_count}, 64'd1);
        wb(0, 32'hFFFFFFFF); bus.raddr2 = 0;
        tick();
        idle();
        #1;
        check("x0_read",     {32'd0, bus.src2},     64'd0);
        check("x0_no_count", {32'd0, bus.wb_count}, 64'd1);

        // Hazard on rd=7, with a stalled issue of rd=12 that must be ignored.
        bus.iss_valid = 1'b1; bus.iss_rd = 7;
        tick();
        bus.iss_rd = 12; bus.raddr2 = 7;
        #1 check("hazard_stall", {63'd0, bus.stall}, 64'd1);
        tick();
        check("stalled_issue_ignored", {63'd0, bus.busy_vec[12]}, 64'd0);
        wb(7, 32'h55);
        #1;
        check("wb_cycle_stall", {63'd0, bus.stall}, BYP ? 64'd0 : 64'd1);
        check("wb_cycle_src2",  {32'd0, bus.src2},  BYP ? 64'h55 : 64'd0);
        tick();
        bus.wb_wen = 1'b0; bus.iss_valid = 1'b0;
        #1;
        check("after_wb_src2", {32'd0, bus.src2}, 64'h55);
        bus.iss_valid = 1'b1; bus.iss_rd = 0;
        #1 check("after_wb_stall", {63'd0, bus.stall}, 64'd0);
        tick();
        idle();

        // Same-cycle issue and writeback to rd=9: issue wins, data lands.
        bus.iss_valid = 1'b1; bus.iss_rd = 9; wb(9, 32'hA5A5_0009);
        tick();
        idle(); bus.raddr1 = 9;
        #1;
        check("simul_busy9", {63'd0, bus.busy_vec[9]}, 64'd1);
        check("simul_reg9",  {32'd0, bus.src1},        64'hA5A5_0009);
        wb(9, 32'h1);
        tick();
        idle();
        #1 check("wb_clears_busy9", {63'd0, bus.busy_vec[9]}, 64'd0);

        // Mixed traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 60; i++) begin
            bus.wb_wen    = ($urandom_range(0, 1) == 1);
            bus.wb_waddr  = AW'($urandom_range(0, NREG-1));
            bus.wb_wdata  = $urandom;
            bus.iss_valid = ($urandom_range(0, 1) == 1);
            bus.iss_rd    = AW'($urandom_range(0, NREG-1));
            bus.raddr1    = AW'($urandom_range(0, 7));
            bus.raddr2    = AW'($urandom_range(0, 7));
            tick();
        end
        idle();
        tick();

        // Counter wrap.
        force dut.r_wb_count = 32'hFFFFFFFF;
        m_count = 32'hFFFFFFFF;
        #1 release dut.r_wb_count;
        wb(4, 32'h44);
        tick();
        idle();
        #1 check("count_wrap", {32'd0, bus.wb_count}, 64'd0);
        tick();

        model_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
